// File: rtl/m_multicycle_ctrl.sv
// Control FSM sequencing a multicycle RV32I-subset datapath over one shared memory.
// Define MC_PERF_CNT_EN to add the cycle / retired-instruction counters.
module m_multicycle_ctrl #(
  parameter int unsigned P_MEM_TIMEOUT = 0
`ifdef MC_PERF_CNT_EN
  , parameter int unsigned P_CNT_W = 32
`endif
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic [6:0] w_opcode,
  input  logic [2:0] w_funct3,
  input  logic       w_funct7_5,
  input  logic       w_zero,
  input  logic       w_mem_ready,
  output logic       w_pc_write,
  output logic       w_adr_src,
  output logic       w_mem_write,
  output logic       w_ir_write,
  output logic [1:0] w_result_src,
  output logic [1:0] w_alu_src_a,
  output logic [1:0] w_alu_src_b,
  output logic [2:0] w_alu_control,
  output logic       w_reg_write,
  output logic       w_instret,
  output logic       w_trap
`ifdef MC_PERF_CNT_EN
  , output logic [P_CNT_W-1:0] w_cycle_cnt,
  output logic [P_CNT_W-1:0] w_instret_cnt
`endif
);

  localparam int unsigned TO_W = (P_MEM_TIMEOUT > 1) ? $clog2(P_MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt, to_cnt_next;
  logic            waiting, timeout, taken;
  logic [2:0]      alu_fn;

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state  <= S_IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_next;
      to_cnt <= to_cnt_next;
    end
  end

  // Memory-wait detection; the current cycle counts toward the timeout budget.
  always_comb begin
    waiting = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !w_mem_ready;
    timeout = (P_MEM_TIMEOUT != 0) && waiting && ((32'(to_cnt) + 32'd1) >= P_MEM_TIMEOUT);
    taken   = ((w_funct3 == 3'b000) && w_zero) || ((w_funct3 == 3'b001) && !w_zero);
  end

  always_comb begin
    alu_fn = ALU_ADD;
    case (w_funct3)
      3'b000:  alu_fn = (state == S_EXEC_R && w_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next    = state;
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_alu_control = ALU_ADD;
    w_reg_write   = 1'b0;
    w_instret     = 1'b0;
    w_trap        = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        if (timeout) begin
          state_next = S_TRAP;
        end else if (w_mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (w_opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        state_next  = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (timeout)          state_next = S_TRAP;
        else if (w_mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_instret    = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src = 1'b1;
        if (timeout) begin
          state_next = S_TRAP;
        end else begin
          w_mem_write = 1'b1;
          if (w_mem_ready) begin
            w_instret  = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_EXEC_R: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = alu_fn;
        state_next    = S_ALUWB;
      end
      S_EXEC_I: begin
        w_alu_src_a   = 2'b10;
        w_alu_src_b   = 2'b01;
        w_alu_control = alu_fn;
        state_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_instret   = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = ALU_SUB;
        w_pc_write    = taken;
        w_instret     = 1'b1;
        state_next    = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        state_next  = S_ALUWB;
      end
      S_TRAP:  w_trap = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  // Wait counter restarts whenever the FSM leaves its current state.
  always_comb begin
    if (state_next != state)            to_cnt_next = '0;
    else if (waiting && to_cnt != '1)   to_cnt_next = to_cnt + TO_W'(1);
    else                                to_cnt_next = to_cnt;
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      w_cycle_cnt   <= '0;
      w_instret_cnt <= '0;
    end else begin
      if (state != S_IDLE && state != S_TRAP) w_cycle_cnt <= w_cycle_cnt + P_CNT_W'(1);
      if (w_instret) w_instret_cnt <= w_instret_cnt + P_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_m_multicycle_ctrl.sv
// Randomized self-checking bench for m_multicycle_ctrl against a per-instruction cycle-trace model.
// Honours MC_PERF_CNT_EN when defined.
module tb_m_multicycle_ctrl;

  localparam int unsigned CW = 32;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n, rst_to_n, ready, zero, funct7_5;
  logic [6:0] opcode;
  logic [2:0] funct3;

  logic       m_pcw, m_adr, m_mw, m_irw, m_rw, m_ir, m_tr;
  logic [1:0] m_rs, m_a, m_b;
  logic [2:0] m_alu;
  logic       t_pcw, t_adr, t_mw, t_irw, t_rw, t_ir, t_tr;
  logic [1:0] t_rs, t_a, t_b;
  logic [2:0] t_alu;
`ifdef MC_PERF_CNT_EN
  logic [CW-1:0] m_cyc, m_ret, t_cyc, t_ret;
`endif

  always #5 clk = ~clk;

  m_multicycle_ctrl #(.P_MEM_TIMEOUT(0)) dut (
    .w_clk(clk), .w_rst_n(rst_n), .w_opcode(opcode), .w_funct3(funct3),
    .w_funct7_5(funct7_5), .w_zero(zero), .w_mem_ready(ready),
    .w_pc_write(m_pcw), .w_adr_src(m_adr), .w_mem_write(m_mw), .w_ir_write(m_irw),
    .w_result_src(m_rs), .w_alu_src_a(m_a), .w_alu_src_b(m_b), .w_alu_control(m_alu),
    .w_reg_write(m_rw), .w_instret(m_ir), .w_trap(m_tr)
`ifdef MC_PERF_CNT_EN
    , .w_cycle_cnt(m_cyc), .w_instret_cnt(m_ret)
`endif
  );

  m_multicycle_ctrl #(.P_MEM_TIMEOUT(4)) dut_to (
    .w_clk(clk), .w_rst_n(rst_to_n), .w_opcode(opcode), .w_funct3(funct3),
    .w_funct7_5(funct7_5), .w_zero(zero), .w_mem_ready(ready),
    .w_pc_write(t_pcw), .w_adr_src(t_adr), .w_mem_write(t_mw), .w_ir_write(t_irw),
    .w_result_src(t_rs), .w_alu_src_a(t_a), .w_alu_src_b(t_b), .w_alu_control(t_alu),
    .w_reg_write(t_rw), .w_instret(t_ir), .w_trap(t_tr)
`ifdef MC_PERF_CNT_EN
    , .w_cycle_cnt(t_cyc), .w_instret_cnt(t_ret)
`endif
  );

  logic [15:0] m_obs, t_obs;
  assign m_obs = {m_pcw, m_adr, m_mw, m_irw, m_rs, m_a, m_b, m_alu, m_rw, m_ir, m_tr};
  assign t_obs = {t_pcw, t_adr, t_mw, t_irw, t_rs, t_a, t_b, t_alu, t_rw, t_ir, t_tr};

  int n_chk = 0, n_pass = 0;
  int sel = 0;
  int exp_cyc = 0, exp_ret = 0;
  logic [15:0] c_f0, c_f1, c_dec, c_madr, c_wb, c_trap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [15:0] v(input logic pcw, adr, mw, irw, input logic [1:0] rs, a, b,
                                    input logic [2:0] alu, input logic rw, ir, tr);
    return {pcw, adr, mw, irw, rs, a, b, alu, rw, ir, tr};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] alu_of(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? SUB : ADD;
      3'b010:  return SLT;
      3'b110:  return OR_;
      3'b111:  return AND_;
      default: return ADD;
    endcase
  endfunction

  // One clock of the active DUT: drive at negedge, check 1 ns later, then advance the counter model.
  task automatic step(input logic [15:0] exp, input logic rdy, input logic rst, input string tag);
    @(negedge clk);
    ready = rdy;
    if (sel == 0) rst_n = rst; else rst_to_n = rst;
    #1;
    chk(tag, 32'(sel == 0 ? m_obs : t_obs), 32'(exp));
`ifdef MC_PERF_CNT_EN
    chk({tag, "_cyc"}, 32'(sel == 0 ? m_cyc : t_cyc), 32'(CW'(exp_cyc)));
    chk({tag, "_ret"}, 32'(sel == 0 ? m_ret : t_ret), 32'(CW'(exp_ret)));
`endif
    if (!rst) begin
      exp_cyc = 0;
      exp_ret = 0;
    end else begin
      if (exp != 16'h0 && !exp[0]) exp_cyc++;
      if (exp[1]) exp_ret++;
    end
  endtask

  // cls: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal; fw/mw = memory wait cycles before ready.
  task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7, input logic z,
                           input int fw, input int mw);
    logic tk;
    case (cls)
      0: opcode = 7'b0000011;
      1: opcode = 7'b0100011;
      2: opcode = 7'b0110011;
      3: opcode = 7'b0010011;
      4: opcode = 7'b1100011;
      default: opcode = 7'b1101111;
    endcase
    funct3 = f3; funct7_5 = f7; zero = z;
    for (int i = 0; i < fw; i++) step(c_f0, 1'b0, 1'b1, "fetch_wait");
    step(c_f1, 1'b1, 1'b1, "fetch");
    step(c_dec, rb(), 1'b1, "decode");
    case (cls)
      0: begin
        step(c_madr, rb(), 1'b1, "lw_memadr");
        for (int i = 0; i < mw; i++)
          step(v(0,1,0,0,2'b00,2'b00,2'b00,ADD,0,0,0), 1'b0, 1'b1, "memread_wait");
        step(v(0,1,0,0,2'b00,2'b00,2'b00,ADD,0,0,0), 1'b1, 1'b1, "memread");
        step(v(0,0,0,0,2'b01,2'b00,2'b00,ADD,1,1,0), rb(), 1'b1, "memwb");
      end
      1: begin
        step(c_madr, rb(), 1'b1, "sw_memadr");
        for (int i = 0; i < mw; i++)
          step(v(0,1,1,0,2'b00,2'b00,2'b00,ADD,0,0,0), 1'b0, 1'b1, "memwrite_wait");
        step(v(0,1,1,0,2'b00,2'b00,2'b00,ADD,0,1,0), 1'b1, 1'b1, "memwrite");
      end
      2, 3: begin
        step(v(0,0,0,0,2'b00,2'b10,(cls == 2) ? 2'b00 : 2'b01, alu_of(cls == 2, f3, f7),0,0,0),
             rb(), 1'b1, (cls == 2) ? "exec_r" : "exec_i");
        step(c_wb, rb(), 1'b1, "aluwb");
      end
      4: begin
        tk = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
        step(v(tk,0,0,0,2'b00,2'b10,2'b00,SUB,0,1,0), rb(), 1'b1, "branch");
      end
      default: begin
        step(v(1,0,0,0,2'b00,2'b01,2'b10,ADD,0,0,0), rb(), 1'b1, "jal");
        step(c_wb, rb(), 1'b1, "jal_wb");
      end
    endcase
  endtask

  initial begin
    c_f0   = v(0,0,0,0,2'b10,2'b00,2'b10,ADD,0,0,0);
    c_f1   = v(1,0,0,1,2'b10,2'b00,2'b10,ADD,0,0,0);
    c_dec  = v(0,0,0,0,2'b00,2'b01,2'b01,ADD,0,0,0);
    c_madr = v(0,0,0,0,2'b00,2'b10,2'b01,ADD,0,0,0);
    c_wb   = v(0,0,0,0,2'b00,2'b00,2'b00,ADD,1,1,0);
    c_trap = v(0,0,0,0,2'b00,2'b00,2'b00,ADD,0,0,1);
    rst_n = 1'b0; rst_to_n = 1'b0; ready = 1'b0; zero = 1'b0; funct7_5 = 1'b0;
    opcode = '0; funct3 = '0;
    repeat (2) @(posedge clk);
    step(16'h0, rb(), 1'b0, "reset");
    step(16'h0, rb(), 1'b1, "idle");

    // Directed cases from the plan.
    run_instr(0, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(1, 3'b010, 1'b0, 1'b0, 0, 3);
    run_instr(4, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(4, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(4, 3'b001, 1'b0, 1'b0, 0, 0);
    run_instr(4, 3'b001, 1'b0, 1'b1, 0, 0);
    run_instr(4, 3'b100, 1'b0, 1'b1, 0, 0);
    run_instr(2, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(3, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(2, 3'b110, 1'b0, 1'b0, 0, 0);
    run_instr(5, 3'b000, 1'b0, 1'b0, 2, 0);

    for (int n = 0; n < 80; n++) begin
      int cls;
      logic [2:0] f3;
      cls = int'($urandom_range(0, 5));
      f3  = 3'($urandom);
      if (cls == 4 && rb()) f3 = {2'b00, rb()};
      run_instr(cls, f3, rb(), rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a load.
    opcode = 7'b0000011;
    step(c_f1, 1'b1, 1'b1, "mid_fetch");
    step(c_dec, rb(), 1'b1, "mid_decode");
    step(c_madr, rb(), 1'b0, "mid_rst");
    step(16'h0, rb(), 1'b1, "mid_idle");

    // Illegal opcode traps until reset.
    opcode = 7'b0000000;
    step(c_f1, 1'b1, 1'b1, "ill_fetch");
    step(c_dec, rb(), 1'b1, "ill_decode");
    for (int i = 0; i < 10; i++) step(c_trap, rb(), 1'b1, "trap_hold");
    step(c_trap, rb(), 1'b0, "trap_rst");
    step(16'h0, rb(), 1'b1, "trap_idle");
    run_instr(3, 3'b111, 1'b0, 1'b0, 1, 0);

    // Timeout instance: main DUT parked in reset.
    @(negedge clk);
    rst_n = 1'b0;
    sel = 1;
    exp_cyc = 0;
    exp_ret = 0;
    step(16'h0, rb(), 1'b1, "to_idle");
    for (int i = 0; i < 4; i++) step(c_f0, 1'b0, 1'b1, "to_wait");
    for (int i = 0; i < 5; i++) step(c_trap, rb(), 1'b1, "to_trap");
    step(c_trap, rb(), 1'b0, "to_rst");
    step(16'h0, rb(), 1'b1, "to_idle2");
    run_instr(0, 3'b010, 1'b0, 1'b0, 3, 3);
    run_instr(1, 3'b010, 1'b0, 1'b0, 3, 3);
    run_instr(2, 3'b111, 1'b0, 1'b0, 0, 0);
    opcode = 7'b0100011;
    step(c_f1, 1'b1, 1'b1, "to_sw_fetch");
    step(c_dec, rb(), 1'b1, "to_sw_decode");
    step(c_madr, rb(), 1'b1, "to_sw_memadr");
    for (int i = 0; i < 3; i++)
      step(v(0,1,1,0,2'b00,2'b00,2'b00,ADD,0,0,0), 1'b0, 1'b1, "to_sw_wait");
    step(v(0,1,0,0,2'b00,2'b00,2'b00,ADD,0,0,0), 1'b0, 1'b1, "to_sw_expire");
    step(c_trap, rb(), 1'b1, "to_sw_trap");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
